// File: rtl/audio_medfilter_axil_slave.sv
// AXI4-Lite control/status register bank for the audio median filter.
// Optional SLVERR responses are enabled by defining AUDIO_MEDFILTER_AXIL_SLVERR_EN.
module audio_medfilter_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_ID_VALUE         = 32'h4D454431
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            sample_valid,
  output logic                            cfg_enable,
  output logic                            cfg_bypass,
  output logic [3:0]                      cfg_window,
  output logic [15:0]                     cfg_threshold
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AUDIO_MEDFILTER_AXIL_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DW-1:0] cfg_q [4];
  logic [DW-1:0] cfg_d [4];
  logic [DW-1:0] cnt_q, cnt_d;
  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [2:0]    aw_idx_q, aw_idx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          awready_q, awready_d, wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  r_state_e      r_state_q, r_state_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  logic          aw_hs, w_hs, wr_fire, wr_err, cnt_clr;
  logic [2:0]    wr_idx, rd_idx;
  logic [DW-1:0] wr_data, rd_word;
  logic [SW-1:0] wr_strb;
  logic          rd_err;
  logic          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A beat arriving this cycle is merged with any previously held half so
  // that AW and W handshaking together still respond on the next cycle.
  assign aw_hs   = S_AXI_AWVALID && awready_q;
  assign w_hs    = S_AXI_WVALID && wready_q;
  assign wr_fire = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[4:2];
  assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    cfg_d     = cfg_q;
    cnt_clr   = 1'b0;
    wr_err    = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[4:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_fire) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (wr_idx)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          for (int b = 0; b < SW; b++)
            if (wr_strb[b]) cfg_d[wr_idx[1:0]][8*b +: 8] = wr_data[8*b +: 8];
        end
        3'd4: begin
          cnt_clr = 1'b1;
          wr_err  = SLVERR_EN && (|wr_strb);
        end
        3'd5:    wr_err = SLVERR_EN && (|wr_strb);
        default: wr_err = SLVERR_EN;
      endcase
      bresp_d = wr_err ? RESP_SLVERR : RESP_OKAY;
    end
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  // Clear beats a coincident sample strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                            cnt_d = '0;
    else if (sample_valid && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  assign rd_idx = S_AXI_ARADDR[4:2];

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_word = cfg_q[rd_idx[1:0]];
      3'd4:                   rd_word = cnt_q;
      3'd5:                   rd_word = C_ID_VALUE;
      default:                rd_err  = SLVERR_EN;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (S_AXI_ARVALID && arready_q) begin
        rdata_d   = rd_word;
        rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
        rvalid_d  = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (S_AXI_RREADY) begin
        rvalid_d  = 1'b0;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      // NOTE: the four config words are software-visible state and must reset, so they stay flops rather than RAM.
      for (int i = 0; i < 4; i++) cfg_q[i] <= '0;
      cnt_q     <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign cfg_enable    = cfg_q[0][0];
  assign cfg_bypass    = cfg_q[0][1];
  assign cfg_window    = cfg_q[1][3:0];
  assign cfg_threshold = cfg_q[2][15:0];

endmodule
